// File: rtl/unified_mem_arbiter.sv
// Arbitrates one byte-wide unified memory between fetch (10-byte reads) and the memory
// stage (8-byte quad reads/writes), moving one little-endian byte per cycle.
module unified_mem_arbiter #(
    parameter int MEM_BYTES = 4096,
    parameter int ADDR_W    = 12,
    parameter int IBYTES    = 10,
    parameter int DBYTES    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [63:0]       d_addr,
    input  logic [63:0]       d_wdata,
    output logic [63:0]       d_rdata,
    output logic              d_done,
    output logic              d_err,
    input  logic              i_req,
    input  logic [63:0]       i_addr,
    output logic [79:0]       i_rdata,
    output logic              i_done,
    output logic              i_err,
    output logic [ADDR_W-1:0] m_addr,
    output logic              m_we,
    output logic [7:0]        m_wdata,
    input  logic [7:0]        m_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;
    typedef enum logic {SIDE_DATA, SIDE_FETCH} side_t;

    localparam int          CNT_W   = $clog2(IBYTES);
    localparam logic [63:0] D_LIMIT = 64'(MEM_BYTES - DBYTES);
    localparam logic [63:0] I_LIMIT = 64'(MEM_BYTES - IBYTES);

    state_t             state;
    side_t              side;
    side_t              last_grant;
    logic               we_q;
    logic [ADDR_W-1:0]  base_q;
    logic [63:0]        wdata_q;
    logic [CNT_W-1:0]   cnt;
    logic [79:0]        rbuf;

    logic               grant_d;
    logic               grant_f;
    logic               grant_err;
    logic [CNT_W-1:0]   last_cnt;

    // In DONE only the other side may be granted: the finishing side still holds its
    // request for this cycle, and granting here keeps busy high across back-to-back accesses.
    always_comb begin
        grant_d = 1'b0;
        grant_f = 1'b0;
        if (state == IDLE) begin
            if (d_req && i_req) begin
                grant_d = (last_grant == SIDE_FETCH);
                grant_f = (last_grant == SIDE_DATA);
            end else begin
                grant_d = d_req;
                grant_f = i_req;
            end
        end else if (state == DONE) begin
            grant_d = d_req && (side == SIDE_FETCH);
            grant_f = i_req && (side == SIDE_DATA);
        end
        // Full 64-bit compare so huge addresses never wrap into the array.
        grant_err = grant_d ? (d_addr > D_LIMIT) : (i_addr > I_LIMIT);
        last_cnt  = (side == SIDE_FETCH) ? CNT_W'(IBYTES - 1) : CNT_W'(DBYTES - 1);
    end

    // NOTE: all state updates use non-blocking assignments so every register samples
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            side       <= SIDE_DATA;
            last_grant <= SIDE_FETCH;
            we_q       <= 1'b0;
            base_q     <= '0;
            wdata_q    <= '0;
            cnt        <= '0;
            rbuf       <= '0;
            d_done     <= 1'b0;
            i_done     <= 1'b0;
            d_err      <= 1'b0;
            i_err      <= 1'b0;
        end else begin
            d_done <= 1'b0;
            i_done <= 1'b0;
            d_err  <= 1'b0;
            i_err  <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (grant_d || grant_f) begin
                        side       <= grant_f ? SIDE_FETCH : SIDE_DATA;
                        last_grant <= grant_f ? SIDE_FETCH : SIDE_DATA;
                        we_q       <= grant_d && d_we;
                        base_q     <= grant_d ? d_addr[ADDR_W-1:0] : i_addr[ADDR_W-1:0];
                        wdata_q    <= d_wdata;
                        cnt        <= '0;
                        rbuf       <= '0;
                        if (grant_err) begin
                            state  <= DONE;
                            d_done <= grant_d;
                            i_done <= grant_f;
                            d_err  <= grant_d;
                            i_err  <= grant_f;
                        end else begin
                            state <= XFER;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                XFER: begin
                    // Bytes shift in from the top: a fetch ends with byte0 at [7:0],
                    // a quad ends with byte0 at [23:16].
                    if (!we_q) rbuf <= {m_rdata, rbuf[79:8]};
                    wdata_q <= {8'h00, wdata_q[63:8]};
                    if (cnt == last_cnt) begin
                        state  <= DONE;
                        d_done <= (side == SIDE_DATA);
                        i_done <= (side == SIDE_FETCH);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Reset wins over an in-flight write: the byte of the reset cycle is not committed.
    assign m_we    = (state == XFER) && we_q && !rst;
    assign m_wdata = m_we ? wdata_q[7:0] : 8'h00;
    assign m_addr  = (state == XFER) ? base_q + ADDR_W'(cnt) : '0;
    assign busy    = (state != IDLE);
    assign d_rdata = (d_done && !d_err && !we_q) ? rbuf[79:16] : 64'h0;
    assign i_rdata = (i_done && !i_err) ? rbuf : 80'h0;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter: byte-wide memory model, vector table of single
// accesses, plus hand-written arbitration and mid-write reset sequences.
module tb_unified_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        d_req, d_we, i_req;
    logic [63:0] d_addr, d_wdata, i_addr;
    logic [63:0] d_rdata;
    logic [79:0] i_rdata;
    logic        d_done, d_err, i_done, i_err;
    logic [11:0] m_addr;
    logic        m_we;
    logic [7:0]  m_wdata, m_rdata;
    logic        busy;

    logic [7:0]  mem [0:4095];
    logic        pre_we = 1'b0;
    logic [11:0] pre_addr = '0;
    logic [7:0]  pre_data = '0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    unified_mem_arbiter dut (
        .clk(clk), .rst(rst),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_done(d_done), .d_err(d_err),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done), .i_err(i_err),
        .m_addr(m_addr), .m_we(m_we), .m_wdata(m_wdata), .m_rdata(m_rdata), .busy(busy)
    );

    always @(posedge clk) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        else if (m_we) mem[m_addr] <= m_wdata;
    end
    assign m_rdata = mem[m_addr];

    typedef struct {
        logic        fetch;
        logic        we;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [79:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        int          exp_wes;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [11:0] a, input logic [7:0] b);
        @(negedge clk);
        pre_we = 1'b1; pre_addr = a; pre_data = b;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    // Called at a negedge; returns at a negedge with the arbiter back in IDLE.
    task automatic run_vec(input vec_t v, output int lat, output logic [79:0] rdata,
                           output logic err, output int wes, output logic other);
        logic done;
        done = 1'b0; lat = -1; rdata = '0; err = 1'b0; wes = 0; other = 1'b0;
        d_req = !v.fetch; i_req = v.fetch; d_we = v.we;
        d_addr = v.addr; i_addr = v.addr; d_wdata = v.wdata;
        for (int c = 1; c <= 30 && !done; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (m_we) wes++;
            if (v.fetch ? i_done : d_done) begin
                done  = 1'b1;
                lat   = c;
                rdata = v.fetch ? i_rdata : {16'h0, d_rdata};
                err   = v.fetch ? i_err : d_err;
                d_req = 1'b0; i_req = 1'b0;
            end
            if (v.fetch ? d_done : i_done) other = 1'b1;
        end
        d_req = 1'b0; i_req = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Both sides request together; reports which finished first and whether busy dropped.
    task automatic run_both(output logic first_fetch, output int drops, output logic timeout,
                            output logic [63:0] drd, output logic [79:0] ird);
        logic dd, id, any;
        dd = 1'b0; id = 1'b0; any = 1'b0; first_fetch = 1'b0; drops = 0; drd = '0; ird = '0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 64'h100;
        i_req = 1'b1; i_addr = 64'h0;
        for (int c = 0; c < 60 && !(dd && id); c++) begin
            @(posedge clk);
            @(negedge clk);
            if (!busy) drops++;
            if (d_done) begin
                if (!any) first_fetch = 1'b0;
                any = 1'b1; dd = 1'b1; d_req = 1'b0; drd = d_rdata;
            end
            if (i_done) begin
                if (!any) first_fetch = 1'b1;
                any = 1'b1; id = 1'b1; i_req = 1'b0; ird = i_rdata;
            end
        end
        timeout = !(dd && id);
        d_req = 1'b0; i_req = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int          lat, wes, drops;
        logic [79:0] rd;
        logic [63:0] drd;
        logic [79:0] ird;
        logic        err, other, first_fetch, timeout;
        logic [7:0]  fetch_bytes [10];
        logic [7:0]  exp_200 [8];

        vecs[0] = '{1'b0, 1'b1, 64'h100, 64'h1122334455667788, 80'h0, 1'b0, 9, 8};
        vecs[1] = '{1'b0, 1'b0, 64'h100, 64'h0, 80'h1122334455667788, 1'b0, 9, 0};
        vecs[2] = '{1'b1, 1'b0, 64'h0, 64'h0, 80'h000000000000000AF230, 1'b0, 11, 0};
        vecs[3] = '{1'b0, 1'b1, 64'hFF9, 64'hDEADDEADDEADDEAD, 80'h0, 1'b1, 1, 0};
        vecs[4] = '{1'b0, 1'b1, 64'hFF8, 64'hA1A2A3A4A5A6A7A8, 80'h0, 1'b0, 9, 8};
        vecs[5] = '{1'b0, 1'b0, 64'hFF8, 64'h0, 80'hA1A2A3A4A5A6A7A8, 1'b0, 9, 0};
        vecs[6] = '{1'b1, 1'b0, 64'hFF7, 64'h0, 80'h0, 1'b1, 1, 0};
        vecs[7] = '{1'b1, 1'b0, 64'hFF6, 64'h0, 80'hA1A2A3A4A5A6A7A8ADAC, 1'b0, 11, 0};
        vecs[8] = '{1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 80'h0, 1'b1, 1, 0};
        vecs[9] = '{1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF, 80'h0, 1'b1, 1, 0};

        fetch_bytes = '{8'h30, 8'hF2, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        exp_200     = '{8'hEF, 8'hBE, 8'hAD, 8'h59, 8'h5E, 8'h5F, 8'h5C, 8'h5D};

        rst = 1'b1;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        i_req = 1'b0; i_addr = '0;
        for (int i = 0; i < 10; i++) preload(12'(i), fetch_bytes[i]);
        for (int i = 0; i < 8; i++) preload(12'(12'h200 + i), 8'(12'h200 + i) ^ 8'h5A);
        for (int i = 12'hFF6; i <= 12'hFFF; i++) preload(12'(i), 8'(i) ^ 8'h5A);
        do_reset();

        check("reset_busy", 80'(busy), 80'h0);
        check("reset_done", 80'({d_done, i_done, d_err, i_err}), 80'h0);
        check("reset_mem_port", 80'({m_we, m_addr, m_wdata}), 80'h0);
        check("reset_rdata", 80'({d_rdata, i_rdata}), 80'h0);

        for (int k = 0; k < 10; k++) begin
            run_vec(vecs[k], lat, rd, err, wes, other);
            check($sformatf("vec%0d_latency", k), 80'(lat), 80'(vecs[k].exp_lat));
            check($sformatf("vec%0d_rdata", k), rd, vecs[k].exp_rdata);
            check($sformatf("vec%0d_err", k), 80'(err), 80'(vecs[k].exp_err));
            check($sformatf("vec%0d_we_cycles", k), 80'(wes), 80'(vecs[k].exp_wes));
            check($sformatf("vec%0d_other_done", k), 80'(other), 80'h0);
            if (k == 0) begin
                check("mem_100", 80'(mem[12'h100]), 80'h88);
                check("mem_107", 80'(mem[12'h107]), 80'h11);
            end
        end

        // Simultaneous requests after reset: data first, then fetch, busy held throughout.
        do_reset();
        run_both(first_fetch, drops, timeout, drd, ird);
        check("arb1_timeout", 80'(timeout), 80'h0);
        check("arb1_first_is_fetch", 80'(first_fetch), 80'h0);
        check("arb1_busy_drops", 80'(drops), 80'h0);
        check("arb1_d_rdata", 80'(drd), 80'h1122334455667788);
        check("arb1_i_rdata", ird, 80'h000000000000000AF230);

        // After a lone data access, a simultaneous pair goes to fetch first.
        run_vec(vecs[1], lat, rd, err, wes, other);
        check("arb_mid_rdata", rd, 80'h1122334455667788);
        run_both(first_fetch, drops, timeout, drd, ird);
        check("arb2_timeout", 80'(timeout), 80'h0);
        check("arb2_first_is_fetch", 80'(first_fetch), 80'h1);
        check("arb2_busy_drops", 80'(drops), 80'h0);

        // Reset during byte 3 of a write to 0x200.
        d_req = 1'b1; d_we = 1'b1; d_addr = 64'h200; d_wdata = 64'hCAFEBABEDEADBEEF;
        @(posedge clk);
        for (int i = 0; i < 3; i++) @(posedge clk);
        @(negedge clk);
        check("rst_mid_addr", 80'(m_addr), 80'h203);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_mid_outputs", 80'({busy, d_done, d_err, i_done, i_err, m_we, m_addr, m_wdata}), 80'h0);
        check("rst_mid_rdata", 80'({d_rdata, i_rdata}), 80'h0);
        d_req = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst_mid_no_done", 80'({d_done, busy}), 80'h0);
        for (int i = 0; i < 8; i++)
            check($sformatf("rst_mid_mem_%0d", i), 80'(mem[12'(12'h200 + i)]), 80'(exp_200[i]));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
